// File: rtl/pipe_stage_if.sv
// pipe_stage_if: handshake/payload bundle between a pipeline stage and its pipe_stage_reg.
interface pipe_stage_if #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 24,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [CTRL_W-1:0]  in_ctrl;
    logic [DATA_W-1:0]  in_data;
    logic               out_valid;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [DATA_W-1:0]  out_data;
    logic [1:0]         act;
    logic [7:0]         hold_cnt;
    logic               perf_clr;
    logic [31:0]        perf_stall;
    logic [31:0]        perf_bubble;
    modport master (
        output stall, flush, in_valid, in_ctrl, in_data, perf_clr,
        input  out_valid, out_ctrl, out_data, act, hold_cnt, perf_stall, perf_bubble
    );
    modport slave (
        input  stall, flush, in_valid, in_ctrl, in_data, perf_clr,
        output out_valid, out_ctrl, out_data, act, hold_cnt, perf_stall, perf_bubble
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with flush, stall-vector hold/bubble and hold tracking.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int DATA_W               = 32,
    parameter int CTRL_W               = 24,
    parameter int STALL_W              = 6,
    parameter int STAGE                = 3,
    parameter bit CLEAR_DATA_ON_BUBBLE = 1'b1
) (
    input logic         clk,
    input logic         rst,
    pipe_stage_if.slave bus
);
    typedef enum logic [1:0] {ACT_FLUSH, ACT_ADV, ACT_HOLD, ACT_BUB} act_t;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    act_t              r_act;
    logic [7:0]        r_hold;
    logic              w_s_up;
    logic              w_s_dn;
    logic              w_take;
    act_t              w_act;
    logic [DATA_W-1:0] w_data;
    logic              w_unused;

    assign w_s_up   = bus.stall[STAGE];
    assign w_unused = ^{bus.stall, bus.perf_clr};

    // The last stage has nobody downstream to stall it, so it can only bubble.
    generate
        if (STAGE < STALL_W - 1) begin : g_dn
            assign w_s_dn = bus.stall[STAGE+1];
        end else begin : g_top
            assign w_s_dn = 1'b0;
        end
    endgenerate

    always_comb begin
        w_act  = bus.flush ? ACT_FLUSH : !w_s_up ? ACT_ADV : w_s_dn ? ACT_HOLD : ACT_BUB;
        w_take = (w_act == ACT_ADV) && bus.in_valid;
        w_data = (w_act == ACT_ADV && (bus.in_valid || !CLEAR_DATA_ON_BUBBLE)) ? bus.in_data
               : CLEAR_DATA_ON_BUBBLE ? '0 : r_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_act   <= ACT_FLUSH;
            r_hold  <= '0;
        end else begin
            r_act  <= w_act;
            r_hold <= (w_act != ACT_HOLD) ? 8'd0 : (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
            if (w_act != ACT_HOLD) begin
                r_valid <= w_take;
                r_ctrl  <= w_take ? bus.in_ctrl : '0;
                r_data  <= w_data;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_ctrl  = r_ctrl;
    assign bus.out_data  = r_data;
    assign bus.act       = r_act;
    assign bus.hold_cnt  = r_hold;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
        end else begin
            r_perf_stall  <= r_perf_stall + {31'd0, w_act == ACT_HOLD};
            r_perf_bubble <= r_perf_bubble + {31'd0, w_act == ACT_BUB};
        end
    end

    assign bus.perf_stall  = r_perf_stall;
    assign bus.perf_bubble = r_perf_bubble;
`else
    assign bus.perf_stall  = '0;
    assign bus.perf_bubble = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg in three configurations
// (default, data retained on bubble, top stage).
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [23:0] in_ctrl;
    logic [31:0] in_data;
    logic        perf_clr;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    pipe_stage_if if0 ();
    pipe_stage_if if1 ();
    pipe_stage_if if2 ();

    assign {if0.stall, if0.flush, if0.in_valid, if0.in_ctrl, if0.in_data, if0.perf_clr} = {stall, flush, in_valid, in_ctrl, in_data, perf_clr};
    assign {if1.stall, if1.flush, if1.in_valid, if1.in_ctrl, if1.in_data, if1.perf_clr} = {stall, flush, in_valid, in_ctrl, in_data, perf_clr};
    assign {if2.stall, if2.flush, if2.in_valid, if2.in_ctrl, if2.in_data, if2.perf_clr} = {stall, flush, in_valid, in_ctrl, in_data, perf_clr};

    pipe_stage_reg #(.STAGE(3)) u0 (.clk(clk), .rst(rst), .bus(if0));
    pipe_stage_reg #(.STAGE(3), .CLEAR_DATA_ON_BUBBLE(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    pipe_stage_reg #(.STAGE(5)) u2 (.clk(clk), .rst(rst), .bus(if2));

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 6'b010101; flush = 1'b0; perf_clr = 1'b0;
        in_valid = 1'b1; in_ctrl = 24'h123456; in_data = 32'hCAFEF00D;
        step(); step();
        chk("rst_valid", {31'd0, if0.out_valid}, 0);
        chk("rst_ctrl", {8'd0, if0.out_ctrl}, 0);
        chk("rst_data", if0.out_data, 0);
        chk("rst_act", {30'd0, if0.act}, 0);
        chk("rst_hold", {24'd0, if0.hold_cnt}, 0);

        rst = 1'b0; stall = 6'b000000; in_valid = 1'b1; in_ctrl = 24'h00ABCD; in_data = 32'hDEADBEEF;
        step();
        chk("adv_valid", {31'd0, if0.out_valid}, 1);
        chk("adv_ctrl", {8'd0, if0.out_ctrl}, 32'h00ABCD);
        chk("adv_data", if0.out_data, 32'hDEADBEEF);
        chk("adv_act", {30'd0, if0.act}, 1);

        in_valid = 1'b0; in_ctrl = 24'hFFFFFF; in_data = 32'h11111111;
        step();
        chk("inv_valid", {31'd0, if0.out_valid}, 0);
        chk("inv_ctrl", {8'd0, if0.out_ctrl}, 0);
        chk("inv_data", if0.out_data, 0);
        chk("inv_act", {30'd0, if0.act}, 1);
        chk("inv_keep_data", if1.out_data, 32'h11111111);
        chk("inv_keep_ctrl", {8'd0, if1.out_ctrl}, 0);

        in_valid = 1'b1; in_ctrl = 24'h000042; in_data = 32'h12345678;
        step();
        stall = 6'b011000; in_ctrl = 24'h555555; in_data = 32'hAAAAAAAA;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("hold_valid", {31'd0, if0.out_valid}, 1);
            chk("hold_ctrl", {8'd0, if0.out_ctrl}, 32'h42);
            chk("hold_data", if0.out_data, 32'h12345678);
            chk("hold_act", {30'd0, if0.act}, 2);
            chk("hold_cnt", {24'd0, if0.hold_cnt}, i);
        end

        stall = 6'b001000;
        step();
        chk("bub_valid", {31'd0, if0.out_valid}, 0);
        chk("bub_ctrl", {8'd0, if0.out_ctrl}, 0);
        chk("bub_data", if0.out_data, 0);
        chk("bub_act", {30'd0, if0.act}, 3);
        chk("bub_hold", {24'd0, if0.hold_cnt}, 0);
        chk("bub_keep_data", if1.out_data, 32'h12345678);
        chk("bub_keep_valid", {31'd0, if1.out_valid}, 0);

        stall = 6'b000000; in_valid = 1'b1; in_ctrl = 24'h000042; in_data = 32'h12345678;
        step();
        stall = 6'b011000; flush = 1'b1; in_data = 32'hBBBBBBBB;
        step();
        chk("fl_valid", {31'd0, if0.out_valid}, 0);
        chk("fl_act", {30'd0, if0.act}, 0);
        chk("fl_data", if0.out_data, 0);
        chk("fl_hold", {24'd0, if0.hold_cnt}, 0);
        chk("fl_keep_data", if1.out_data, 32'h12345678);
        chk("fl_keep_ctrl", {8'd0, if1.out_ctrl}, 0);
        chk("fl_keep_valid", {31'd0, if1.out_valid}, 0);

        flush = 1'b0; stall = 6'b000000; in_data = 32'h12345678;
        step();
        chk("top_load", {31'd0, if2.out_valid}, 1);
        stall = 6'b100000;
        step();
        chk("top_act", {30'd0, if2.act}, 3);
        chk("top_valid", {31'd0, if2.out_valid}, 0);
        chk("top_mid_adv", {30'd0, if0.act}, 1);

        stall = 6'b011000;
        repeat (255) step();
        chk("sat_255", {24'd0, if0.hold_cnt}, 255);
        repeat (45) step();
        chk("sat_hold", {24'd0, if0.hold_cnt}, 255);
        chk("sat_act", {30'd0, if0.act}, 2);
        chk("sat_data", if0.out_data, 32'h12345678);

        rst = 1'b1;
        step();
        chk("midrst_hold", {24'd0, if0.hold_cnt}, 0);
        chk("midrst_valid", {31'd0, if0.out_valid}, 0);
        chk("midrst_data", if0.out_data, 0);
        chk("midrst_pstall", if0.perf_stall, 0);

        rst = 1'b0; stall = 6'b011000;
        repeat (10) step();
        stall = 6'b001000;
        repeat (4) step();
        stall = 6'b011000; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf_stall", if0.perf_stall, PERF ? 10 : 0);
        chk("perf_bubble", if0.perf_bubble, PERF ? 4 : 0);
        perf_clr = 1'b1;
        step();
        chk("perf_clr_stall", if0.perf_stall, 0);
        chk("perf_clr_bubble", if0.perf_bubble, 0);
        perf_clr = 1'b0;
        step();
        chk("perf_after_clr", if0.perf_stall, PERF ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
